edge_conv3x3: RTL and testbench

Parametrised 3×3 gradient-magnitude filter that supersedes the fixed 8-bit Sobel stage. It sits between the line buffer, which supplies one vertical 3-pixel column per clock, and the video output mux. It selects Sobel or Prewitt kernels and can output combined or single-axis magnitude. It gates invalid border pixels with a row/column fill state machine and re-aligns dv/hs/vs to the pixel pipeline.

---
 rtl/edge_conv3x3.sv | 238 +++++++++++++++++++++++
 tb/tb_edge_conv3x3.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/edge_conv3x3.sv
// edge_conv3x3 -- 3x3 gradient-magnitude filter (Sobel / Prewitt) fed by a
// line buffer that delivers one vertical 3-pixel column per clock.
//
// Optional feature macro: EDGE_CONV_THRESH_EN
//   defined   : thresh_i exists, conv_o is binarised (all ones / zero)
//   undefined : conv_o is the saturated magnitude
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   vect_in[2:0]        column, [0] newest row, [2] oldest row
//   dv_i, hs_i, vs_i    data valid, hsync, vsync
//   mode_i              00 Sobel |Gx|+|Gy|, 01 Sobel |Gx|, 10 Sobel |Gy|,
//                       11 Prewitt |Gx|+|Gy| (latched on vs_i rising edge)
//   thresh_i            binarisation threshold (EDGE_CONV_THRESH_EN only)
//   conv_o              filtered pixel, zero whenever dv_o is low
//   dv_o, hs_o, vs_o    gated valid and ungated syncs, all LAT cycles late
//   line_end_o          one-cycle pulse after the last pixel of each line
//
// The data path is four register stages (window, Gx/Gy, abs+combine,
// saturate); LAT must stay at 4 for the sync lines to line up with it.
module edge_conv3x3 #(
   parameter int unsigned COLORDEPTH = 8,
   parameter int unsigned GAIN_SHIFT = 1,
   parameter int unsigned LAT        = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [2:0][COLORDEPTH-1:0] vect_in,
   input  logic                       dv_i,
   input  logic                       hs_i,
   input  logic                       vs_i,
   input  logic [1:0]                 mode_i,
`ifdef EDGE_CONV_THRESH_EN
   input  logic [COLORDEPTH-1:0]      thresh_i,
`endif
   output logic [COLORDEPTH-1:0]      conv_o,
   output logic                       dv_o,
   output logic                       hs_o,
   output logic                       vs_o,
   output logic                       line_end_o
);

   localparam int unsigned CD = COLORDEPTH;
   localparam int unsigned GW = COLORDEPTH + 3;   // signed gradient width
   localparam int unsigned AW = COLORDEPTH + 2;   // absolute gradient width

   localparam logic [1:0] MODE_SOBEL_X = 2'b01;
   localparam logic [1:0] MODE_SOBEL_Y = 2'b10;
   localparam logic [1:0] MODE_PREWITT = 2'b11;

   typedef enum logic [1:0] {
      FILL0 = 2'd0,
      FILL1 = 2'd1,
      RUN   = 2'd2
   } row_state_e;

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   row_state_e                 state_q, state_d;
   logic [1:0]                 cnt_q, cnt_d;
   logic                       dv_prev_q;
   logic                       vs_prev_q;
   logic                       frame_sync_q, frame_sync_d;
   logic [1:0]                 mode_q, mode_d;

   logic [2:0][CD-1:0]         col0_q, col1_q, col2_q;
   logic signed [GW-1:0]       gx_q, gy_q, gx_d, gy_d;
   logic [GW-1:0]              mag_q, mag_d;
   logic [CD-1:0]              conv_q, conv_d;
   logic                       line_end_q, line_end_d;

   logic [LAT-1:0]             gv_sr_q;   // gated valid
   logic [LAT-1:0]             dv_sr_q;   // ungated valid
   logic [LAT-1:0]             hs_sr_q;
   logic [LAT-1:0]             vs_sr_q;

   logic                       dv_fall_c;
   logic                       vs_rise_c;
   logic                       col_ok_c;
   logic                       row_ok_c;
   logic                       gate_c;

   // ------------------------------------------------------------------
   // Helpers
   // ------------------------------------------------------------------
   function automatic logic signed [GW-1:0] sdiff(input logic [CD-1:0] a,
                                                  input logic [CD-1:0] b);
      return $signed(GW'(a)) - $signed(GW'(b));
   endfunction

   // Weighted sum of three differences: 1,2,1 (Sobel) or 1,1,1 (Prewitt)
   function automatic logic signed [GW-1:0] wsum(input logic signed [GW-1:0] d0,
                                                 input logic signed [GW-1:0] d1,
                                                 input logic signed [GW-1:0] d2,
                                                 input logic               flat);
      return flat ? (d0 + d1 + d2) : (d0 + (d1 <<< 1) + d2);
   endfunction

   // ------------------------------------------------------------------
   // Edge detects and border qualifiers for the pixel being sampled
   // ------------------------------------------------------------------
   always_comb begin
      dv_fall_c = dv_prev_q & ~dv_i;
      vs_rise_c = vs_i & ~vs_prev_q;
      col_ok_c  = (cnt_q == 2'd2);
      row_ok_c  = (state_q == RUN);
      gate_c    = dv_i & col_ok_c & row_ok_c;
   end

   // Row fill FSM: two completed lines after vsync before output opens.
   // Line ends only count once a vsync has been seen since reset.
   always_comb begin
      state_d = state_q;
      if (vs_i) begin
         state_d = FILL0;
      end else if (dv_fall_c && frame_sync_q) begin
         case (state_q)
            FILL0:   state_d = FILL1;
            FILL1:   state_d = RUN;
            RUN:     state_d = RUN;
            default: state_d = FILL0;
         endcase
      end
   end

   // Column counter, frame sync flag and frame-rate mode latch
   always_comb begin
      cnt_d        = 2'd0;
      frame_sync_d = frame_sync_q | vs_i;
      mode_d       = mode_q;
      if (dv_i) begin
         cnt_d = (cnt_q == 2'd2) ? 2'd2 : cnt_q + 2'd1;
      end
      if (vs_rise_c) begin
         mode_d = mode_i;
      end
   end

   // Stage 2: signed gradients from the 3x3 window
   always_comb begin
      logic signed [GW-1:0] dx0, dx1, dx2;
      logic signed [GW-1:0] dy0, dy1, dy2;
      logic                 flat;
      flat = (mode_q == MODE_PREWITT);
      dx0  = sdiff(col0_q[0], col2_q[0]);
      dx1  = sdiff(col0_q[1], col2_q[1]);
      dx2  = sdiff(col0_q[2], col2_q[2]);
      dy0  = sdiff(col0_q[0], col0_q[2]);
      dy1  = sdiff(col1_q[0], col1_q[2]);
      dy2  = sdiff(col2_q[0], col2_q[2]);
      gx_d = wsum(dx0, dx1, dx2, flat);
      gy_d = wsum(dy0, dy1, dy2, flat);
   end

   // Stage 3: absolute values, axis selection and gain shift
   always_comb begin
      logic [AW-1:0] ax, ay;
      logic [GW-1:0] sum;
      ax = AW'(gx_q[GW-1] ? -gx_q : gx_q);
      ay = AW'(gy_q[GW-1] ? -gy_q : gy_q);
      case (mode_q)
         MODE_SOBEL_X: sum = GW'(ax);
         MODE_SOBEL_Y: sum = GW'(ay);
         default:      sum = GW'(ax) + GW'(ay);
      endcase
      mag_d = sum >> GAIN_SHIFT;
   end

   // Stage 4: saturate (optionally binarise) and gate with the valid
   always_comb begin
      logic [CD-1:0] sat;
      logic [CD-1:0] pix;
      sat = (|mag_q[GW-1:CD]) ? '1 : mag_q[CD-1:0];
`ifdef EDGE_CONV_THRESH_EN
      pix = (sat >= thresh_i) ? '1 : '0;
`else
      pix = sat;
`endif
      conv_d     = gv_sr_q[2] ? pix : '0;
      line_end_d = dv_sr_q[LAT-1] & ~dv_sr_q[LAT-2];
   end

   // ------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= FILL0;
         cnt_q        <= 2'd0;
         dv_prev_q    <= 1'b0;
         vs_prev_q    <= 1'b0;
         frame_sync_q <= 1'b0;
         mode_q       <= 2'b00;
         col0_q       <= '0;
         col1_q       <= '0;
         col2_q       <= '0;
         gx_q         <= '0;
         gy_q         <= '0;
         mag_q        <= '0;
         conv_q       <= '0;
         line_end_q   <= 1'b0;
         gv_sr_q      <= '0;
         dv_sr_q      <= '0;
         hs_sr_q      <= '0;
         vs_sr_q      <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         dv_prev_q    <= dv_i;
         vs_prev_q    <= vs_i;
         frame_sync_q <= frame_sync_d;
         mode_q       <= mode_d;
         // Window only advances on accepted pixels
         if (dv_i) begin
            col2_q <= col1_q;
            col1_q <= col0_q;
            col0_q <= vect_in;
         end
         gx_q         <= gx_d;
         gy_q         <= gy_d;
         mag_q        <= mag_d;
         conv_q       <= conv_d;
         line_end_q   <= line_end_d;
         gv_sr_q      <= {gv_sr_q[LAT-2:0], gate_c};
         dv_sr_q      <= {dv_sr_q[LAT-2:0], dv_i};
         hs_sr_q      <= {hs_sr_q[LAT-2:0], hs_i};
         vs_sr_q      <= {vs_sr_q[LAT-2:0], vs_i};
      end
   end

   assign conv_o     = conv_q;
   assign dv_o       = gv_sr_q[LAT-1];
   assign hs_o       = hs_sr_q[LAT-1];
   assign vs_o       = vs_sr_q[LAT-1];
   assign line_end_o = line_end_q;

endmodule

// File: tb/tb_edge_conv3x3.sv
// Bench for edge_conv3x3: frame-level stimulus with a kernel-based
// reference model; expected pixels go through a queue, syncs are checked
// against the driven history.
module tb_edge_conv3x3;

   localparam int unsigned CD   = 8;
   localparam int unsigned GS   = 1;
   localparam int unsigned LAT  = 4;
   localparam int          W    = 16;
   localparam int          H    = 8;
   localparam int          HMAX = 16384;

   logic               clk = 1'b0;
   logic               rst;
   logic [2:0][CD-1:0] vect_in;
   logic               dv_i, hs_i, vs_i;
   logic [1:0]         mode_i;
`ifdef EDGE_CONV_THRESH_EN
   logic [CD-1:0]      thresh_i;
`endif
   logic [CD-1:0]      conv_o;
   logic               dv_o, hs_o, vs_o, line_end_o;

   edge_conv3x3 #(.COLORDEPTH(CD), .GAIN_SHIFT(GS), .LAT(LAT)) dut (
      .clk        (clk),
      .rst        (rst),
      .vect_in    (vect_in),
      .dv_i       (dv_i),
      .hs_i       (hs_i),
      .vs_i       (vs_i),
      .mode_i     (mode_i),
`ifdef EDGE_CONV_THRESH_EN
      .thresh_i   (thresh_i),
`endif
      .conv_o     (conv_o),
      .dv_o       (dv_o),
      .hs_o       (hs_o),
      .vs_o       (vs_o),
      .line_end_o (line_end_o)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   bit h_rst [HMAX];
   bit h_dv  [HMAX];
   bit h_hs  [HMAX];
   bit h_vs  [HMAX];
   bit h_gv  [HMAX];
   int exp_q [$];
   int img   [H][W];
   int tests = 0;
   int fails = 0;
   bit mon_en = 1'b0;
   bit synced = 1'b0;
   int fmode  = 0;

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s cyc=%0d got %0d expected %0d", name, cyc, act, exp);
      end
   endtask

   function automatic bit any_rst(input int lo, input int hi);
      for (int k = lo; k <= hi; k++) begin
         if (k < 0) return 1'b1;
         if (h_rst[k]) return 1'b1;
      end
      return 1'b0;
   endfunction

   function automatic int pix(input int y, input int x);
      if (y < 0) return 0;
      return img[y][x];
   endfunction

   // Reference: window spans image rows y-2..y and columns x-2..x
   function automatic int model_px(input int y, input int x, input int mode);
      int w [3];
      int gx, gy, ax, ay, mag;
      if (mode == 3) w = '{1, 1, 1};
      else           w = '{1, 2, 1};
      gx = 0;
      gy = 0;
      for (int d = 0; d < 3; d++) begin
         gx += w[d] * (img[y-d][x] - img[y-d][x-2]);
         gy += w[d] * (img[y][x-d] - img[y-2][x-d]);
      end
      ax = (gx < 0) ? -gx : gx;
      ay = (gy < 0) ? -gy : gy;
      case (mode)
         1:       mag = ax;
         2:       mag = ay;
         default: mag = ax + ay;
      endcase
      mag = mag >> GS;
      if (mag > 255) mag = 255;
`ifdef EDGE_CONV_THRESH_EN
      mag = (mag >= int'(thresh_i)) ? 255 : 0;
`endif
      return mag;
   endfunction

   task automatic drive(input bit r, input bit dv, input bit hs, input bit vs,
                        input int p0, input int p1, input int p2, input bit gv);
      @(posedge clk);
      #1;
      rst        = r;
      dv_i       = dv;
      hs_i       = hs;
      vs_i       = vs;
      vect_in[0] = CD'(p0);
      vect_in[1] = CD'(p1);
      vect_in[2] = CD'(p2);
      // Pixels still inside the pipeline are lost on reset
      if (r) begin
         for (int k = cyc - 3; k < cyc; k++) begin
            if (k >= 0 && h_gv[k]) void'(exp_q.pop_back());
         end
      end
      h_rst[cyc] = r;
      h_dv[cyc]  = dv;
      h_hs[cyc]  = hs;
      h_vs[cyc]  = vs;
      h_gv[cyc]  = gv & ~r;
   endtask

   task automatic idle(input int n, input bit hs);
      repeat (n) drive(1'b0, 1'b0, hs, 1'b0, 0, 0, 0, 1'b0);
   endtask

   task automatic fill(input int kind);
      for (int y = 0; y < H; y++) begin
         for (int x = 0; x < W; x++) begin
            case (kind)
               0:       img[y][x] = 128;
               1:       img[y][x] = (x >= 8) ? 10 : 0;
               2:       img[y][x] = (x >= 8) ? 255 : 0;
               3:       img[y][x] = int'($urandom_range(0, 255));
               default: img[y][x] = ($urandom_range(0, 1) == 1) ? 255 : 0;
            endcase
         end
      end
   endtask

   task automatic run_frame(input int kind, input int mode0, input int mode_mid,
                            input int rst_y, input int rst_x);
      bit r, gv;
      fill(kind);
      mode_i = 2'(mode0);
      idle(2, 1'b0);
      fmode  = mode0;
      synced = 1'b1;
      repeat (2) drive(1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 0, 1'b0);
      idle(3, 1'b0);
      for (int y = 0; y < H; y++) begin
         if (y == 3 && mode_mid >= 0) mode_i = 2'(mode_mid);
         idle(2, 1'b1);
         idle(1, 1'b0);
         for (int x = 0; x < W; x++) begin
            r = (y == rst_y) && (x == rst_x);
            if (r) synced = 1'b0;
            gv = synced && (y >= 2) && (x >= 2);
            if (gv) exp_q.push_back(model_px(y, x, fmode));
            drive(r, 1'b1, 1'b0, 1'b0, pix(y, x), pix(y - 1, x), pix(y - 2, x), gv);
         end
         idle(5, 1'b0);
      end
   endtask

   // Monitor: syncs against history, pixel data against the queue
   int m;
   bit r4, r5;
   always @(negedge clk) begin
      if (mon_en) begin
         m  = cyc;
         r4 = any_rst(m - 4, m - 1);
         r5 = any_rst(m - 5, m - 1);
         if (r4) begin
            check("dv_o", int'(dv_o), 0);
            check("hs_o", int'(hs_o), 0);
            check("vs_o", int'(vs_o), 0);
         end else begin
            check("dv_o", int'(dv_o), int'(h_gv[m-4]));
            check("hs_o", int'(hs_o), int'(h_hs[m-4]));
            check("vs_o", int'(vs_o), int'(h_vs[m-4]));
         end
         if (r5) check("line_end_o", int'(line_end_o), 0);
         else    check("line_end_o", int'(line_end_o), int'(h_dv[m-5] & ~h_dv[m-4]));
         if (dv_o) begin
            if (exp_q.size() == 0) check("conv_o_unexpected", 1, 0);
            else                   check("conv_o", int'(conv_o), exp_q.pop_front());
         end else begin
            check("conv_o_gated", int'(conv_o), 0);
         end
      end
   end

   initial begin
      rst     = 1'b1;
      dv_i    = 1'b0;
      hs_i    = 1'b0;
      vs_i    = 1'b0;
      vect_in = '0;
      mode_i  = 2'b00;
`ifdef EDGE_CONV_THRESH_EN
      thresh_i = 8'd0;
`endif
      drive(1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b0);
      mon_en = 1'b1;
      drive(1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b0);
      idle(3, 1'b0);

`ifdef EDGE_CONV_THRESH_EN
      thresh_i = 8'd20;
      run_frame(1, 0, -1, -1, -1);
      thresh_i = 8'd21;
      run_frame(1, 0, -1, -1, -1);
      thresh_i = 8'd60;
      run_frame(3, 0, -1, -1, -1);
      thresh_i = 8'd100;
      run_frame(4, 3, -1, -1, -1);
      thresh_i = 8'd20;
`endif
      run_frame(0, 0, -1, -1, -1);   // flat: all zero, border gating
      run_frame(1, 0, -1, -1, -1);   // 0->10 step, Sobel sum
      run_frame(1, 2, -1, -1, -1);   // Gy only
      run_frame(1, 3, -1, -1, -1);   // Prewitt
      run_frame(2, 1, -1, -1, -1);   // saturation
      run_frame(3, 0, 2, -1, -1);    // mode change deferred to next frame
      run_frame(3, 2, -1, -1, -1);
      run_frame(3, 1, -1, 4, 7);     // reset mid-line
      run_frame(3, 3, -1, -1, -1);
      for (int i = 0; i < 4; i++) begin
         run_frame(3 + int'($urandom_range(0, 1)), int'($urandom_range(0, 3)), -1, -1, -1);
      end
      idle(10, 1'b0);
      check("exp_q_drained", exp_q.size(), 0);
      mon_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
